// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_pkg
// Description : Shared types and helpers for the instruction fetch unit.
//               Holds the fetch controller state encoding, the sequential
//               PC increment and the word-alignment helper that is applied
//               to redirect targets.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_unit_pkg;

    // Fetch controller states. IDLE is only ever visited out of reset.
    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_e;

    // Byte distance between consecutive instructions.
    localparam logic [31:0] PC_STEP = 32'd4;

    // Instruction addresses are always word aligned. Masking (rather than
    // slicing) keeps every bit of the incoming target in use.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Owns the architectural PC, issues one instruction fetch at a
//               time to instruction memory (valid/ready request, single
//               response-valid beat per accepted request) and presents the
//               fetched word to decode over a valid/ready handshake.
//               Sequential PC+4 is generated internally; branch/jump
//               redirects arrive with the target already computed.
// Ports       : clk, rst                        - clock, sync active-high reset
//               redirect_valid/redirect_target  - taken branch/jump and target
//               imem_req_valid/ready, imem_addr - fetch request channel
//               imem_resp_valid/imem_resp_data  - fetch response channel
//               inst_valid/ready, inst_pc/data  - instruction to decode
//               drop_cnt                        - saturating count of
//                                                 responses discarded
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_addr,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst_pc,
    output logic [31:0]      inst_data,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ifu_state_e       state_q,     state_d;
    logic [31:0]      pc_q,        pc_d;
    logic             drop_q,      drop_d;
    logic [31:0]      inst_pc_q,   inst_pc_d;
    logic [31:0]      inst_data_q, inst_data_d;
    logic [CNT_W-1:0] drop_cnt_q,  drop_cnt_d;

    logic [31:0]      w_target;

    assign w_target = word_align(redirect_target);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IFU_IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            inst_pc_q   <= 32'd0;
            inst_data_q <= 32'd0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            inst_pc_q   <= inst_pc_d;
            inst_data_q <= inst_data_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        inst_pc_d   = inst_pc_q;
        inst_data_d = inst_data_q;
        drop_cnt_d  = drop_cnt_q;

        unique case (state_q)
            IFU_IDLE: begin
                state_d = IFU_REQ;
            end

            IFU_REQ: begin
                if (imem_req_ready) begin
                    state_d = IFU_WAIT;
                    // A redirect coinciding with acceptance leaves a stale
                    // request in flight whose response must be thrown away.
                    drop_d  = redirect_valid;
                end
                // Unaccepted request simply retargets next cycle.
                if (redirect_valid) begin
                    pc_d = w_target;
                end
            end

            IFU_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = IFU_REQ;
                    if (drop_q || redirect_valid) begin
                        drop_d = 1'b0;
                        if (drop_cnt_q != CNT_MAX) begin
                            drop_cnt_d = drop_cnt_q + CNT_ONE;
                        end
                        if (redirect_valid) begin
                            pc_d = w_target;
                        end
                    end else begin
                        state_d     = IFU_HOLD;
                        inst_data_d = imem_resp_data;
                        inst_pc_d   = pc_q;
                        pc_d        = pc_q + PC_STEP;
                    end
                end else if (redirect_valid) begin
                    // Only one request can be outstanding, so a single
                    // flag suffices however many redirects pile up.
                    pc_d   = w_target;
                    drop_d = 1'b1;
                end
            end

            IFU_HOLD: begin
                // Redirect flushes the buffered instruction even if decode
                // is accepting it in the same cycle.
                if (redirect_valid) begin
                    pc_d    = w_target;
                    state_d = IFU_REQ;
                end else if (inst_ready) begin
                    state_d = IFU_REQ;
                end
            end

            default: begin
                state_d = IFU_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state and registers only
    // ------------------------------------------------------------------
    assign imem_req_valid = (state_q == IFU_REQ);
    assign imem_addr      = (state_q == IFU_REQ) ? pc_q : 32'd0;
    assign inst_valid     = (state_q == IFU_HOLD);
    assign inst_pc        = inst_pc_q;
    assign inst_data      = inst_data_q;
    assign drop_cnt       = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Self-checking bench for pc_fetch_unit. A transaction-level
//               reference model tracks the expected PC, the outstanding
//               fetch, pending discards, the buffered instruction and the
//               dropped-response count; random and directed stimulus are
//               compared against it every cycle. A second instance with
//               RESET_PC = 0xFFFF_FFFC shares all inputs to cover PC wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam int unsigned CNT_W    = 4;
    localparam int          DROP_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             redirect_valid = 1'b0;
    logic [31:0]      redirect_target = 32'd0;
    logic             imem_req_ready = 1'b0;
    logic             imem_resp_valid = 1'b0;
    logic [31:0]      imem_resp_data = 32'd0;
    logic             inst_ready = 1'b0;

    logic             imem_req_valid, inst_valid;
    logic [31:0]      imem_addr, inst_pc, inst_data;
    logic [CNT_W-1:0] drop_cnt;

    logic             d2_req_valid, d2_inst_valid;
    logic [31:0]      d2_addr, d2_inst_pc, d2_inst_data;
    logic [CNT_W-1:0] d2_drop_cnt;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_pc(inst_pc), .inst_data(inst_data), .drop_cnt(drop_cnt)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(CNT_W)) dut_wrap (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req_valid(d2_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(d2_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(d2_inst_valid), .inst_ready(inst_ready),
        .inst_pc(d2_inst_pc), .inst_data(d2_inst_data), .drop_cnt(d2_drop_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc   = 32'd0;
    bit          m_idle = 1'b1;
    bit          m_out  = 1'b0;   // accepted request awaiting response
    bit          m_disc = 1'b0;   // that response is to be discarded
    bit          m_hold = 1'b0;
    logic [31:0] m_hpc  = 32'd0;
    logic [31:0] m_hdat = 32'd0;
    int          m_drops = 0;
    int          resp_timer = 0;
    logic [31:0] out_addr = 32'd0;
    int          n_deliv = 0;

    int k_ready = 100, k_iready = 100, k_redir = 0, lat_lo = 1, lat_hi = 1;
    bit chk_wrap = 1'b0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic bit m_req();
        return !m_idle && !m_out && !m_hold;
    endfunction

    task automatic model_reset();
        m_pc = 32'd0; m_idle = 1'b1; m_out = 1'b0; m_disc = 1'b0;
        m_hold = 1'b0; m_hpc = 32'd0; m_hdat = 32'd0; m_drops = 0;
    endtask

    // One clock cycle: check current outputs, drive inputs for the next
    // edge, then advance the model across that edge.
    task automatic step(input bit f_rst, input bit f_redir, input logic [31:0] f_tgt,
                        input bit f_stray);
        bit          req, old_out, old_hold, red;
        logic [31:0] tgt;
        @(negedge clk);
        req = m_req();
        check("inst_valid", inst_valid, m_hold);
        check("inst_pc", inst_pc, m_hpc);
        check("inst_data", inst_data, m_hdat);
        check("req_valid", imem_req_valid, req);
        if (req || m_idle) check("imem_addr", imem_addr, req ? m_pc : 32'd0);
        check("drop_cnt", drop_cnt, 32'(m_drops));
        if (chk_wrap && req) check("wrap_addr", d2_addr, m_pc - 32'd4);

        rst             = f_rst;
        redirect_valid  = f_redir || ($urandom_range(99) < k_redir);
        redirect_target = f_redir ? f_tgt : $urandom;
        imem_req_ready  = ($urandom_range(99) < k_ready);
        inst_ready      = ($urandom_range(99) < k_iready);
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (!f_rst && m_out) begin
            if (resp_timer <= 1) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem(out_addr);
            end else begin
                resp_timer--;
            end
        end else if (f_stray && !m_out) begin
            imem_resp_valid = 1'b1;
        end

        red = redirect_valid;
        tgt = redirect_target & 32'hFFFF_FFFC;
        if (f_rst) begin
            model_reset();
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else begin
            old_out  = m_out;
            old_hold = m_hold;
            if (req && imem_req_ready) begin
                m_out      = 1'b1;
                m_disc     = red;
                out_addr   = m_pc;
                resp_timer = $urandom_range(lat_hi, lat_lo);
            end
            if (old_out && imem_resp_valid) begin
                m_out = 1'b0;
                if (m_disc || red) begin
                    m_disc = 1'b0;
                    if (m_drops < DROP_MAX) m_drops++;
                end else begin
                    m_hold = 1'b1;
                    m_hpc  = m_pc;
                    m_hdat = mem(m_pc);
                    m_pc   = m_pc + 32'd4;
                end
            end else if (old_out && red) begin
                m_disc = 1'b1;
            end
            if (old_hold && (red || inst_ready)) begin
                m_hold = 1'b0;
                if (!red) n_deliv++;
            end
            if (red) m_pc = tgt;
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    // Samples outputs just after the edge that follows the last step.
    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  guard;
        bit  ok;

        // 1: reset release, always-ready memory, 1-cycle response
        k_ready = 100; k_iready = 100; k_redir = 0; lat_lo = 1; lat_hi = 1;
        chk_wrap = 1'b1;
        do_reset();
        n_deliv = 0;
        repeat (12) step(1'b0, 1'b0, 32'd0, 1'b0);
        check("t1_delivered", 32'(n_deliv), 32'd3);
        chk_wrap = 1'b0;

        // 2: decode stalls while an instruction is held
        do_reset();
        ok = 1'b0;
        for (guard = 0; guard < 20 && !ok; guard++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            ok = m_hold;
        end
        check("t2_reach_hold", ok, 1'b1);
        k_iready = 0;
        repeat (6) step(1'b0, 1'b0, 32'd0, 1'b0);
        k_iready = 100;

        // 3: redirect while waiting on the fetch of 0x8
        do_reset();
        lat_lo = 3; lat_hi = 3;
        ok = 1'b0;
        for (guard = 0; guard < 40 && !ok; guard++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            ok = m_out && (out_addr == 32'h8) && (resp_timer > 1);
        end
        check("t3_reach_wait8", ok, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        ok = 1'b0;
        for (guard = 0; guard < 10 && !ok; guard++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            ok = m_req();
        end
        check("t3_reach_req", ok, 1'b1);
        peek();
        check("t3_addr", imem_addr, 32'h0000_0100);
        check("t3_drop_cnt", 32'(drop_cnt), 32'd1);

        // 4: redirect to unaligned target in HOLD with decode ready
        do_reset();
        lat_lo = 1; lat_hi = 1;
        ok = 1'b0;
        for (guard = 0; guard < 20 && !ok; guard++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            ok = m_hold;
        end
        check("t4_reach_hold", ok, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0203, 1'b0);
        peek();
        check("t4_inst_valid", inst_valid, 1'b0);
        check("t4_req_valid", imem_req_valid, 1'b1);
        check("t4_addr", imem_addr, 32'h0000_0200);

        // 6: reset while waiting, then a stray response
        do_reset();
        lat_lo = 3; lat_hi = 3;
        ok = 1'b0;
        for (guard = 0; guard < 20 && !ok; guard++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            ok = m_out && (resp_timer > 1);
        end
        check("t6_reach_wait", ok, 1'b1);
        do_reset();
        k_ready = 0;
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        peek();
        check("t6_drop_cnt", 32'(drop_cnt), 32'd0);
        check("t6_req_valid", imem_req_valid, 1'b1);
        check("t6_addr", imem_addr, 32'h0000_0000);
        k_ready = 100;

        // Randomised traffic with changing knobs and occasional resets
        for (int blk = 0; blk < 16; blk++) begin
            k_ready  = $urandom_range(100, 30);
            k_iready = $urandom_range(100, 20);
            k_redir  = $urandom_range(35, 0);
            lat_lo   = 1;
            lat_hi   = $urandom_range(4, 1);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(299) == 0) do_reset();
                else step(1'b0, 1'b0, 32'd0, !m_out && ($urandom_range(9) == 0) && m_idle);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
